mux32_to_1: RTL and testbench
=============================

Name: mux32_to_1

Overview:
- Registered 32-to-1 single-bit multiplexer: selects bit I[S] from a 32-bit input word using a 5-bit select.
- Provides both a combinational result and a one-cycle-registered result with a valid flag.
- Used as a generic bit-select leaf in datapath and control logic.
- One clock domain; asynchronous active-high reset.

Parameters:
- RESET_Y, default 1'b0: value loaded into the registered output Y on reset.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  reset, asynchronous, active-high
- S  input  5  select index, 0..31
- I  input  32  data word; I[k] is mux input k
- in_valid  input  1  qualifies S/I for capture
- Y_comb  output  1  combinational I[S], no latency
- Y  output  1  registered selected bit
- out_valid  output  1  Y holds a freshly captured value

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- Y_comb = I[S] at all times:
  - Purely combinational; independent of clk, rst and in_valid.
  - Every 5-bit S value is legal (0..31), so there is no out-of-range case.
- Reset:
  - While rst=1: Y = RESET_Y and out_valid = 0, immediately and without waiting for a clock edge.
  - Reset asserted mid-operation discards any pending capture.
  - First capture is possible on the first rising edge with rst=0.
- Capture, on rising clk edge with rst=0:
  - in_valid=1: Y <= I[S]; out_valid <= 1.
  - in_valid=0: Y holds its previous value; out_valid <= 0.
- Latency: one cycle from in_valid/S/I sampled to Y/out_valid.
- Throughput: one capture per cycle; no backpressure and no ready signal.
- Back-to-back valid cycles each produce a new Y on the following cycle.
- Changes to S or I between clock edges affect only Y_comb, never Y.
- Bit ordering: S=0 selects I[0] (LSB); S=31 selects I[31] (MSB).
- No other state; no internal FSM.

Optional Feature:
- Macro: MUX32_TO_1_ONEHOT_EN
- Defined:
  - Adds output port sel_oh (output, 32 bits): registered one-hot decode of S.
  - Captured under the same in_valid rule as Y: sel_oh[S] = 1, all other bits 0.
  - Reset value 32'h0, applied asynchronously with rst.
  - Holds its value when in_valid=0.
  - Invariant when out_valid=1: Y == |(sel_oh & I_captured).
- Undefined:
  - sel_oh port and its register are absent.
  - All other behaviour unchanged.

Test Plan:
- Reset check: assert rst=1 with no clock edge -> Y=RESET_Y (0), out_valid=0 immediately. Release rst, in_valid=0, run 3 clocks -> Y stays 0, out_valid=0.
- Basic select: S=0 with I=32'd0, then 32'd1, then 32'd2, in_valid=1 for each (hold each for 20 ns).
  - Y_comb = 0, 1, 0 immediately.
  - Y = 0, 1, 0 one cycle after each capture, with out_valid=1.
- Extremes:
  - S=31, I=32'h8000_0000 -> Y=1.
  - S=31, I=32'h7FFF_FFFF -> Y=0.
  - S=5, I=~(32'h1<<5) -> Y=0; then S=5, I=32'h20 -> Y=1.
- Hold: capture S=3, I=32'h8 (Y=1), then in_valid=0 with I=32'h0 -> Y stays 1, out_valid=0, Y_comb=0.
- Async reset mid-stream: alternating S=0/S=1 with I=32'h1, in_valid=1; assert rst between clock edges -> Y and out_valid clear without a clock edge.
- Sweep: S=0..31 with I=32'hA5A5_5A5A, in_valid=1 each cycle -> Y tracks I[S] one cycle later. With MUX32_TO_1_ONEHOT_EN defined, sel_oh = 1<<S on the same cycle.

Source files
------------

// File: rtl/mux32_to_1.sv
// mux32_to_1: 32-to-1 single-bit multiplexer with a combinational result and a
// one-cycle registered result qualified by out_valid.
// Optional feature macro: MUX32_TO_1_ONEHOT_EN adds a registered one-hot decode
// of the select (sel_oh) captured alongside Y.
module mux32_to_1 #(
    parameter logic RESET_Y = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  S,
    input  logic [31:0] I,
    input  logic        in_valid,
    output logic        Y_comb,
    output logic        Y,
    output logic        out_valid
`ifdef MUX32_TO_1_ONEHOT_EN
    ,
    output logic [31:0] sel_oh
`endif
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 5;

    logic              w_sel_bit;
    logic              r_y;
    logic              r_valid;

    // Bit select of the data word; every 5-bit select is in range.
    always_comb begin
        w_sel_bit = I[S];
    end

    assign Y_comb = w_sel_bit;

    // Capture the selected bit on valid cycles; Y holds otherwise, valid pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y     <= RESET_Y;
            r_valid <= 1'b0;
        end else begin
            if (in_valid) begin
                r_y <= w_sel_bit;
            end
            r_valid <= in_valid;
        end
    end

    assign Y         = r_y;
    assign out_valid = r_valid;

`ifdef MUX32_TO_1_ONEHOT_EN
    logic [DATA_W-1:0] w_sel_oh;
    logic [DATA_W-1:0] r_sel_oh;

    // One-hot decode of the select index.
    always_comb begin
        w_sel_oh = '0;
        for (int unsigned k = 0; k < DATA_W; k++) begin
            if (S == SEL_W'(k)) begin
                w_sel_oh[k] = 1'b1;
            end
        end
    end

    // Register the decode under the same capture rule as Y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel_oh <= '0;
        end else if (in_valid) begin
            r_sel_oh <= w_sel_oh;
        end
    end

    assign sel_oh = r_sel_oh;
`endif

endmodule

// File: tb/tb_mux32_to_1.sv
// Self-checking bench for mux32_to_1: directed scenarios plus randomized traffic
// checked against an arithmetic reference model (bit k of I is (I >> k) & 1).
module tb_mux32_to_1;

    logic        clk;
    logic        rst;
    logic [4:0]  S;
    logic [31:0] I;
    logic        in_valid;
    logic        Y_comb;
    logic        Y;
    logic        out_valid;
`ifdef MUX32_TO_1_ONEHOT_EN
    logic [31:0] sel_oh;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: what Y / out_valid / sel_oh should hold now.
    logic        exp_y;
    logic        exp_v;
    logic [31:0] exp_oh;

    mux32_to_1 dut (
        .clk       (clk),
        .rst       (rst),
        .S         (S),
        .I         (I),
        .in_valid  (in_valid),
        .Y_comb    (Y_comb),
        .Y         (Y),
        .out_valid (out_valid)
`ifdef MUX32_TO_1_ONEHOT_EN
        ,
        .sel_oh    (sel_oh)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    function automatic logic ref_bit(input logic [4:0] s, input logic [31:0] i);
        logic [31:0] sh;
        sh = i >> s;
        return sh[0];
    endfunction

    task automatic drive(input logic [4:0] s, input logic [31:0] i, input logic v);
        S        = s;
        I        = i;
        in_valid = v;
    endtask

    // Advance one clock: update the model at the rising edge, return at the falling edge.
    task automatic step();
        @(posedge clk);
        if (in_valid) begin
            exp_y  = ref_bit(S, I);
            exp_oh = 32'h1 << S;
        end
        exp_v = in_valid;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        n_tests++;
        if (Y !== 1'b0) begin
            n_fail++; $display("FAIL reset_async_y: got %b want 0", Y);
        end
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_async_valid: got %b want 0", out_valid);
        end
`ifdef MUX32_TO_1_ONEHOT_EN
        n_tests++;
        if (sel_oh !== 32'h0) begin
            n_fail++; $display("FAIL reset_async_oh: got %h want 0", sel_oh);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        exp_y = 1'b0; exp_v = 1'b0; exp_oh = 32'h0;
        drive(5'd7, 32'hFFFF_FFFF, 1'b0);
        for (int n = 0; n < 3; n++) begin
            step();
            n_tests++;
            if (Y !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: got Y=%b valid=%b want Y=0 valid=0", n, Y, out_valid);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] words [3];
        logic        want  [3];
        words[0] = 32'd0; words[1] = 32'd1; words[2] = 32'd2;
        want[0]  = 1'b0;  want[1]  = 1'b1;  want[2]  = 1'b0;
        for (int n = 0; n < 3; n++) begin
            drive(5'd0, words[n], 1'b1);
            #1;
            n_tests++;
            if (Y_comb !== want[n]) begin
                n_fail++; $display("FAIL basic_comb[%0d]: got %b want %b", n, Y_comb, want[n]);
            end
            step();
            n_tests++;
            if (Y !== want[n] || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_reg[%0d]: got Y=%b valid=%b want Y=%b valid=1", n, Y, out_valid, want[n]);
            end
        end
    endtask

    task automatic test_extremes();
        logic [4:0]  ss   [4];
        logic [31:0] ii   [4];
        logic        want [4];
        ss[0] = 5'd31; ii[0] = 32'h8000_0000;   want[0] = 1'b1;
        ss[1] = 5'd31; ii[1] = 32'h7FFF_FFFF;   want[1] = 1'b0;
        ss[2] = 5'd5;  ii[2] = ~(32'h1 << 5);   want[2] = 1'b0;
        ss[3] = 5'd5;  ii[3] = 32'h20;          want[3] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            drive(ss[n], ii[n], 1'b1);
            #1;
            n_tests++;
            if (Y_comb !== want[n]) begin
                n_fail++; $display("FAIL extreme_comb[%0d]: got %b want %b", n, Y_comb, want[n]);
            end
            step();
            n_tests++;
            if (Y !== want[n] || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL extreme_reg[%0d]: got Y=%b valid=%b want Y=%b valid=1", n, Y, out_valid, want[n]);
            end
        end
    endtask

    task automatic test_hold();
        drive(5'd3, 32'h8, 1'b1);
        step();
        n_tests++;
        if (Y !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL hold_capture: got Y=%b valid=%b want Y=1 valid=1", Y, out_valid);
        end
        drive(5'd3, 32'h0, 1'b0);
        #1;
        n_tests++;
        if (Y_comb !== 1'b0) begin
            n_fail++; $display("FAIL hold_comb: got %b want 0", Y_comb);
        end
        for (int n = 0; n < 2; n++) begin
            step();
            n_tests++;
            if (Y !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_reg[%0d]: got Y=%b valid=%b want Y=1 valid=0", n, Y, out_valid);
            end
`ifdef MUX32_TO_1_ONEHOT_EN
            n_tests++;
            if (sel_oh !== 32'h8) begin
                n_fail++; $display("FAIL hold_oh[%0d]: got %h want 00000008", n, sel_oh);
            end
`endif
        end
    endtask

    task automatic test_async_reset();
        for (int n = 0; n < 5; n++) begin
            drive(5'(n % 2), 32'h1, 1'b1);
            step();
        end
        n_tests++;
        if (Y !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL arst_before: got Y=%b valid=%b want Y=1 valid=1", Y, out_valid);
        end
        #3 rst = 1'b1;
        #1;
        n_tests++;
        if (Y !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL arst_immediate: got Y=%b valid=%b want Y=0 valid=0", Y, out_valid);
        end
`ifdef MUX32_TO_1_ONEHOT_EN
        n_tests++;
        if (sel_oh !== 32'h0) begin
            n_fail++; $display("FAIL arst_oh: got %h want 0", sel_oh);
        end
`endif
        @(posedge clk);
        #1;
        n_tests++;
        if (Y !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL arst_held: got Y=%b valid=%b want Y=0 valid=0", Y, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        drive(5'd0, 32'h0, 1'b0);
        exp_y = 1'b0; exp_v = 1'b0; exp_oh = 32'h0;
    endtask

    task automatic test_sweep();
        for (int s = 0; s < 32; s++) begin
            drive(5'(s), 32'hA5A5_5A5A, 1'b1);
            #1;
            n_tests++;
            if (Y_comb !== ref_bit(5'(s), 32'hA5A5_5A5A)) begin
                n_fail++; $display("FAIL sweep_comb[%0d]: got %b want %b", s, Y_comb, ref_bit(5'(s), 32'hA5A5_5A5A));
            end
            step();
            n_tests++;
            if (Y !== exp_y || out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL sweep_reg[%0d]: got Y=%b valid=%b want Y=%b valid=1", s, Y, out_valid, exp_y);
            end
`ifdef MUX32_TO_1_ONEHOT_EN
            n_tests++;
            if (sel_oh !== exp_oh) begin
                n_fail++; $display("FAIL sweep_oh[%0d]: got %h want %h", s, sel_oh, exp_oh);
            end
`endif
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++) begin
            drive(5'($urandom_range(31)), 32'($urandom), 1'($urandom_range(3) != 0));
            #1;
            n_tests++;
            if (Y_comb !== ref_bit(S, I)) begin
                n_fail++; $display("FAIL rand_comb[%0d]: got %b want %b", n, Y_comb, ref_bit(S, I));
            end
            // Wiggle the inputs between edges; only Y_comb may follow.
            #3 I = ~I;
            #1 I = ~I;
            step();
            n_tests++;
            if (Y !== exp_y || out_valid !== exp_v) begin
                n_fail++;
                $display("FAIL rand_reg[%0d]: got Y=%b valid=%b want Y=%b valid=%b", n, Y, out_valid, exp_y, exp_v);
            end
`ifdef MUX32_TO_1_ONEHOT_EN
            n_tests++;
            if (sel_oh !== exp_oh) begin
                n_fail++; $display("FAIL rand_oh[%0d]: got %h want %h", n, sel_oh, exp_oh);
            end
`endif
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(5'd0, 32'h0, 1'b0);
        exp_y = 1'b0; exp_v = 1'b0; exp_oh = 32'h0;
        test_reset();
        test_basic();
        test_extremes();
        test_hold();
        test_async_reset();
        test_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
